fft_r2sdf_bf_stage: RTL and testbench



---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_r2sdf_bf_stage_if.sv | 22 ++
 rtl/sdf_delay_line.sv | 27 ++
 rtl/fft_r2sdf_bf_stage.sv | 78 +++++++
 tb/tb_fft_r2sdf_bf_stage.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the PUSCH FFT pipeline stages.
package fft_pkg;

    localparam int WIDTH_DEF = 14;

    typedef struct packed {
        logic signed [WIDTH_DEF-1:0] re;
        logic signed [WIDTH_DEF-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [WIDTH_DEF:0] re;
        logic signed [WIDTH_DEF:0] im;
    } cplx_ext_t;

    // Widen a complex sample by one bit, keeping its signed value.
    function automatic cplx_ext_t sext(input cplx_t x);
        cplx_ext_t y;
        y.re = {x.re[WIDTH_DEF-1], x.re};
        y.im = {x.im[WIDTH_DEF-1], x.im};
        return y;
    endfunction

endpackage

// File: rtl/fft_r2sdf_bf_stage_if.sv
// Sample stream into and butterfly results out of one R2SDF stage.
interface fft_r2sdf_bf_stage_if #(
    parameter int WIDTH = fft_pkg::WIDTH_DEF
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    out_valid;
    logic signed [WIDTH:0]   out_re;
    logic signed [WIDTH:0]   out_im;
    logic                    out_phase;

    modport master (
        output in_valid, in_re, in_im,
        input  out_valid, out_re, out_im, out_phase
    );

    modport slave (
        input  in_valid, in_re, in_im,
        output out_valid, out_re, out_im, out_phase
    );
endinterface

// File: rtl/sdf_delay_line.sv
// Feedback delay line for SDF stages: advances one entry per accepted sample.
module sdf_delay_line #(
    parameter int DEPTH = 8,
    parameter int DW    = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          shift,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DEPTH];

    // Shift register; entry DEPTH-1 is the oldest and forms the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (shift) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/fft_r2sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly, unrounded WIDTH+1 outputs.
import fft_pkg::*;

module fft_r2sdf_bf_stage #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DELAY = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fft_r2sdf_bf_stage_if.slave        bus
);

    localparam int CW = (DELAY > 1) ? $clog2(2 * DELAY) : 1;
    localparam int EW = WIDTH + 1;

    logic [CW-1:0]        cnt;
    logic                 primed;
    logic                 phase;
    logic signed [EW-1:0] x_re, x_im;
    logic signed [EW-1:0] h_re, h_im;
    logic signed [EW-1:0] sum_re, sum_im;
    logic signed [EW-1:0] dif_re, dif_im;
    logic [2*EW-1:0]      dl_din, dl_dout;

    assign phase = cnt[CW-1];
    assign x_re  = {bus.in_re[WIDTH-1], bus.in_re};
    assign x_im  = {bus.in_im[WIDTH-1], bus.in_im};
    assign h_re  = dl_dout[2*EW-1:EW];
    assign h_im  = dl_dout[EW-1:0];

    // Head is always a first-half input here, so neither result can overflow EW bits.
    assign sum_re = h_re + x_re;
    assign sum_im = h_im + x_im;
    assign dif_re = h_re - x_re;
    assign dif_im = h_im - x_im;

    assign dl_din = phase ? {dif_re, dif_im} : {x_re, x_im};

    sdf_delay_line #(
        .DEPTH (DELAY),
        .DW    (2 * EW)
    ) u_dl (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (bus.in_valid),
        .din   (dl_din),
        .dout  (dl_dout)
    );

    // Sample counter and primed flag; wrap is natural since 2*DELAY is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            primed <= 1'b0;
        end else if (bus.in_valid) begin
            cnt    <= cnt + CW'(1);
            primed <= primed | phase;
        end
    end

    // Output register: first-half head outputs are only trusted once a second half has run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            bus.out_phase <= 1'b0;
        end else if (bus.in_valid) begin
            bus.out_valid <= phase | primed;
            bus.out_phase <= phase;
            bus.out_re    <= phase ? sum_re : h_re;
            bus.out_im    <= phase ? sum_im : h_im;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_r2sdf_bf_stage.sv
// Directed and randomized checks of the R2SDF butterfly stage at DELAY 1, 2 and 8.
module tb_fft_r2sdf_bf_stage;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    logic               o_v;
    logic signed [14:0] o_re;
    logic signed [14:0] o_im;
    logic               o_ph;

    fft_r2sdf_bf_stage_if #(.WIDTH(14)) b1 ();
    fft_r2sdf_bf_stage_if #(.WIDTH(14)) b2 ();
    fft_r2sdf_bf_stage_if #(.WIDTH(14)) b8 ();

    fft_r2sdf_bf_stage #(.WIDTH(14), .DELAY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    fft_r2sdf_bf_stage #(.WIDTH(14), .DELAY(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    fft_r2sdf_bf_stage #(.WIDTH(14), .DELAY(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream 1..8, imag 0, on DELAY=2: expected valid/real/phase per accepted sample.
    int  base_in  [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    bit  base_v   [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
    int  base_re  [8] = '{0, 0, 4, 6, -2, -2, 12, 14};
    bit  base_ph  [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

    task automatic capture(input int sel);
        case (sel)
            1: begin o_v = b1.out_valid; o_re = b1.out_re; o_im = b1.out_im; o_ph = b1.out_phase; end
            2: begin o_v = b2.out_valid; o_re = b2.out_re; o_im = b2.out_im; o_ph = b2.out_phase; end
            default: begin o_v = b8.out_valid; o_re = b8.out_re; o_im = b8.out_im; o_ph = b8.out_phase; end
        endcase
    endtask

    // One clock: optionally present a sample to the selected instance, sample outputs 1 ns after the edge.
    task automatic cycle(input int sel, input bit v, input int re, input int im);
        b1.in_valid = v && (sel == 1);
        b2.in_valid = v && (sel == 2);
        b8.in_valid = v && (sel == 8);
        b1.in_re = 14'(re); b1.in_im = 14'(im);
        b2.in_re = 14'(re); b2.in_im = 14'(im);
        b8.in_re = 14'(re); b8.in_im = 14'(im);
        @(posedge clk);
        #1;
        capture(sel);
        b1.in_valid = 1'b0;
        b2.in_valid = 1'b0;
        b8.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        for (int s = 0; s < 3; s++) begin
            capture(s == 0 ? 1 : (s == 1 ? 2 : 8));
            n_vec++;
            if (o_v !== 1'b0 || o_re !== 15'sd0 || o_im !== 15'sd0 || o_ph !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state inst=%0d got v=%b re=%0d im=%0d ph=%b want all zero",
                         s, o_v, o_re, o_im, o_ph);
            end
        end
        do_reset();
        cycle(2, 1'b0, 0, 0);
        n_vec++;
        if (o_v !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle got v=%b want 0", o_v);
        end
    endtask

    task automatic test_basic(input int gap);
        logic signed [14:0] er;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(2, 1'b1, base_in[k], 0);
            er = 15'(base_re[k]);
            n_vec++;
            if (base_v[k]) begin
                if (o_v !== 1'b1 || o_re !== er || o_im !== 15'sd0 || o_ph !== base_ph[k]) begin
                    n_err++;
                    $display("FAIL basic_gap%0d k=%0d got v=%b re=%0d im=%0d ph=%b want v=1 re=%0d im=0 ph=%b",
                             gap, k, o_v, o_re, o_im, o_ph, er, base_ph[k]);
                end
            end else if (o_v !== 1'b0) begin
                n_err++;
                $display("FAIL basic_gap%0d_unprimed k=%0d got v=%b want 0", gap, k, o_v);
            end
            for (int g = 0; g < gap; g++) begin
                cycle(2, 1'b0, 99, 99);
                n_vec++;
                if (o_v !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_quiet k=%0d g=%0d got v=%b want 0", k, g, o_v);
                end
            end
        end
    endtask

    task automatic test_extremes();
        int xi [6] = '{-8192, 8191, -8192, -8192, 0, 0};
        int ev [6] = '{0, 0, 1, 1, 1, 1};
        int ex [6] = '{0, 0, -16384, -1, 0, 16383};
        bit ep [6] = '{0, 0, 1, 1, 0, 0};
        logic signed [14:0] er;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(2, 1'b1, xi[k], xi[k]);
            er = 15'(ex[k]);
            n_vec++;
            if (ev[k] == 1) begin
                if (o_v !== 1'b1 || o_re !== er || o_im !== er || o_ph !== ep[k]) begin
                    n_err++;
                    $display("FAIL extremes k=%0d got v=%b re=%0d im=%0d ph=%b want v=1 re=%0d im=%0d ph=%b",
                             k, o_v, o_re, o_im, o_ph, er, er, ep[k]);
                end
            end else if (o_v !== 1'b0) begin
                n_err++;
                $display("FAIL extremes_unprimed k=%0d got v=%b want 0", k, o_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ev [4] = '{0, 0, 1, 1};
        int ex [4] = '{0, 0, 4, 6};
        logic signed [14:0] er;
        do_reset();
        cycle(2, 1'b1, 1, 0);
        cycle(2, 1'b1, 2, 0);
        cycle(2, 1'b1, 3, 0);
        n_vec++;
        if (o_v !== 1'b1 || o_re !== 15'sd4) begin
            n_err++;
            $display("FAIL midreset_pre got v=%b re=%0d want v=1 re=4", o_v, o_re);
        end
        rst_n = 1'b0;
        #1;
        capture(2);
        n_vec++;
        if (o_v !== 1'b0 || o_re !== 15'sd0) begin
            n_err++;
            $display("FAIL midreset_async got v=%b re=%0d want v=0 re=0", o_v, o_re);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle(2, 1'b1, k + 1, 0);
            er = 15'(ex[k]);
            n_vec++;
            if (ev[k] == 1) begin
                if (o_v !== 1'b1 || o_re !== er || o_ph !== 1'b1) begin
                    n_err++;
                    $display("FAIL midreset_after k=%0d got v=%b re=%0d ph=%b want v=1 re=%0d ph=1",
                             k, o_v, o_re, o_ph, er);
                end
            end else if (o_v !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_after_unprimed k=%0d got v=%b want 0", k, o_v);
            end
        end
    endtask

    task automatic test_complex();
        do_reset();
        cycle(1, 1'b1, 3, 5);
        n_vec++;
        if (o_v !== 1'b0) begin
            n_err++;
            $display("FAIL complex_first got v=%b want 0", o_v);
        end
        cycle(1, 1'b1, -1, -2);
        n_vec++;
        if (o_v !== 1'b1 || o_re !== 15'sd2 || o_im !== 15'sd3 || o_ph !== 1'b1) begin
            n_err++;
            $display("FAIL complex_sum got v=%b re=%0d im=%0d ph=%b want v=1 re=2 im=3 ph=1",
                     o_v, o_re, o_im, o_ph);
        end
        cycle(1, 1'b1, 0, 0);
        n_vec++;
        if (o_v !== 1'b1 || o_re !== 15'sd4 || o_im !== 15'sd7 || o_ph !== 1'b0) begin
            n_err++;
            $display("FAIL complex_diff got v=%b re=%0d im=%0d ph=%b want v=1 re=4 im=7 ph=0",
                     o_v, o_re, o_im, o_ph);
        end
    endtask

    // Frame-level reference: first half is buffered; second half yields a+b now and a-b next frame.
    task automatic test_random();
        int  cur_re [8], cur_im [8];
        int  nd_re [8], nd_im [8];
        int  pd_re [8], pd_im [8];
        bit  have_prev;
        int  xr, xi, er_i, ei_i;
        bit  ev;
        logic signed [14:0] er, ei;
        int  errs_here;
        errs_here = 0;
        have_prev = 1'b0;
        for (int i = 0; i < 8; i++) begin pd_re[i] = 0; pd_im[i] = 0; end
        do_reset();
        for (int f = 0; f < 1000; f++) begin
            for (int k = 0; k < 16; k++) begin
                while ($urandom_range(0, 9) < 3) begin
                    cycle(8, 1'b0, 0, 0);
                    n_vec++;
                    if (o_v !== 1'b0) begin
                        n_err++;
                        errs_here++;
                        if (errs_here < 10) $display("FAIL random_stall f=%0d k=%0d got v=%b want 0", f, k, o_v);
                    end
                end
                xr = int'($urandom_range(0, 16383)) - 8192;
                xi = int'($urandom_range(0, 16383)) - 8192;
                if (k < 8) begin
                    cur_re[k] = xr; cur_im[k] = xi;
                    er_i = pd_re[k]; ei_i = pd_im[k]; ev = have_prev;
                end else begin
                    er_i = cur_re[k-8] + xr; ei_i = cur_im[k-8] + xi; ev = 1'b1;
                    nd_re[k-8] = cur_re[k-8] - xr; nd_im[k-8] = cur_im[k-8] - xi;
                end
                cycle(8, 1'b1, xr, xi);
                er = 15'(er_i);
                ei = 15'(ei_i);
                n_vec++;
                if (ev) begin
                    if (o_v !== 1'b1 || o_re !== er || o_im !== ei || o_ph !== (k >= 8)) begin
                        n_err++;
                        errs_here++;
                        if (errs_here < 10)
                            $display("FAIL random f=%0d k=%0d got v=%b re=%0d im=%0d ph=%b want v=1 re=%0d im=%0d ph=%b",
                                     f, k, o_v, o_re, o_im, o_ph, er, ei, (k >= 8));
                    end
                end else if (o_v !== 1'b0) begin
                    n_err++;
                    errs_here++;
                    if (errs_here < 10) $display("FAIL random_unprimed f=%0d k=%0d got v=%b want 0", f, k, o_v);
                end
                if (k == 15) begin
                    for (int i = 0; i < 8; i++) begin pd_re[i] = nd_re[i]; pd_im[i] = nd_im[i]; end
                    have_prev = 1'b1;
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        b1.in_valid = 1'b0; b1.in_re = '0; b1.in_im = '0;
        b2.in_valid = 1'b0; b2.in_re = '0; b2.in_im = '0;
        b8.in_valid = 1'b0; b8.in_re = '0; b8.in_im = '0;
        test_reset();
        test_basic(0);
        test_basic(3);
        test_extremes();
        test_reset_mid();
        test_complex();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
